// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_done,
  output logic [DATA_WIDTH-1:0]           req_rdata,
  output logic                            req_err,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic                            PWRITE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  input  logic [DATA_WIDTH-1:0]           PRDATA,
  input  logic                            PREADY,
  input  logic                            PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("apb_rr_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;

  logic                   found;
  logic [IDX_W-1:0]       win_idx;
  logic                   timeout;
  logic                   complete;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_ACCESS && !PREADY) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    timeout = (state_q == S_ACCESS) && !PREADY &&
              (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  always_comb timeout = 1'b0;
`endif

  // Scan starts one past the previous owner and wraps; first pending requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = last_q;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid[(32'(last_q) + i) % NUM_REQ]) begin
        found   = 1'b1;
        win_idx = IDX_W'((32'(last_q) + i) % NUM_REQ);
      end
    end
  end

  // Completion is suppressed while reset is asserted so an aborted transfer never reports done.
  always_comb begin
    complete  = HRESETn && (state_q == S_ACCESS) && (PREADY || timeout);
    req_done  = complete ? grant_q : '0;
    req_err   = complete && (PREADY ? PSLVERR : 1'b1);
    req_rdata = (complete && PREADY && !pwrite_q) ? PRDATA : '0;
    PSEL      = (state_q != S_IDLE);
    PENABLE   = (state_q == S_ACCESS);
    PADDR     = paddr_q;
    PWRITE    = pwrite_q;
    PWDATA    = pwdata_q;
    grant     = grant_q;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_SETUP;
          grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          last_d   = win_idx;
          paddr_d  = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          pwrite_d = req_write[win_idx];
          if (req_write[win_idx]) begin
            pwdata_d = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY || timeout) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_REQ - 1);
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// Scoreboard bench for apb_rr_master_arbiter with a wait-state programmable APB slave.
module tb_apb_rr_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 2;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_write;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_done;
  logic [DW-1:0]     req_rdata;
  logic              req_err;
  logic [NR-1:0]     grant;
  logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]     PADDR;
  logic [DW-1:0]     PWDATA, PRDATA;

  apb_rr_master_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err), .grant(grant),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  // Slave model: PREADY rises after wait_states stalled ACCESS cycles.
  int          wait_states = 0;
  int          acc_cnt = 0;
  logic [31:0] rd_val = '0;
  logic        slverr = 1'b0;
  assign PREADY  = (acc_cnt >= wait_states);
  assign PRDATA  = rd_val;
  assign PSLVERR = slverr;
  always @(posedge HCLK) acc_cnt <= (PSEL && PENABLE && !PREADY) ? acc_cnt + 1 : 0;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  int   n_checks = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   pen_run = 0;
  int   last_pen_run = 0;
  logic prev_psel = 1'b0;
  logic [AW-1:0] prev_paddr = '0;
  logic [NR-1:0] exp_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] a, input logic w,
                      input logic [31:0] rd, input logic er);
    exp_t e;
    e.idx = i; e.addr = a; e.wr = w; e.rdata = rd; e.err = er;
    sb.push_back(e);
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_write[i]          = w;
    req_valid[i]          = 1'b1;
  endtask

  // Returns at posedge+1 once done_cnt reaches n, or after a bounded number of cycles.
  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 300) begin
      @(posedge HCLK);
      k++;
    end
    check("wait_done_bound", 64'(done_cnt >= n), 64'd1);
    #1;
  endtask

  always @(negedge HCLK) begin
    if (HRESETn === 1'b1) begin
      check("penable_implies_psel", 64'(PENABLE && !PSEL), 64'd0);
      check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      if (PSEL && prev_psel) check("paddr_stable", PADDR, prev_paddr);
      if (PSEL && !PENABLE) check("setup_after_idle", 64'(prev_psel), 64'd0);
      pen_run = PENABLE ? pen_run + 1 : 0;
      if (req_done != '0) begin
        done_cnt++;
        last_pen_run = pen_run;
        if (sb.size() == 0) begin
          check("unexpected_done", req_done, 64'd0);
        end else begin
          e_cur = sb.pop_front();
          exp_mask = '0;
          exp_mask[e_cur.idx] = 1'b1;
          check("done_winner", req_done, exp_mask);
          check("grant_at_done", grant, exp_mask);
          check("paddr_at_done", PADDR, e_cur.addr);
          check("pwrite_at_done", PWRITE, e_cur.wr);
          check("rdata_at_done", req_rdata, e_cur.rdata);
          check("err_at_done", req_err, e_cur.err);
        end
      end
      prev_psel  = PSEL;
      prev_paddr = PADDR;
    end else begin
      check("no_done_in_reset", req_done, 64'd0);
      prev_psel = 1'b0;
      pen_run   = 0;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_psel"}, PSEL, 64'd0);
    check({tag, "_penable"}, PENABLE, 64'd0);
    check({tag, "_paddr"}, PADDR, 64'd0);
    check({tag, "_pwrite"}, PWRITE, 64'd0);
    check({tag, "_pwdata"}, PWDATA, 64'd0);
    check({tag, "_grant"}, grant, 64'd0);
    check({tag, "_done"}, req_done, 64'd0);
    check({tag, "_err"}, req_err, 64'd0);
    check({tag, "_rdata"}, req_rdata, 64'd0);
  endtask

  initial begin
    int base;
    HRESETn = 1'b0;
    req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    check_idle_outputs("reset");

    // Single write with zero wait states: SETUP, then ACCESS+done, then idle.
    @(posedge HCLK); #1;
    push(0, 32'h1000_0040, 1'b1, 32'h0, 1'b0);
    issue(0, 32'h1000_0040, 1'b1, 32'hDEAD_BEEF);
    @(negedge HCLK);
    check("t1_idle_psel", PSEL, 64'd0);
    @(negedge HCLK);
    check("t1_setup_psel", PSEL, 64'd1);
    check("t1_setup_penable", PENABLE, 64'd0);
    check("t1_setup_paddr", PADDR, 64'h1000_0040);
    check("t1_setup_pwrite", PWRITE, 64'd1);
    check("t1_setup_pwdata", PWDATA, 64'hDEAD_BEEF);
    check("t1_setup_grant", grant, 64'b01);
    @(negedge HCLK);
    check("t1_access_penable", PENABLE, 64'd1);
    check("t1_access_done", req_done, 64'b01);
    @(posedge HCLK); #1;
    req_valid = '0;
    @(negedge HCLK);
    check("t1_after_psel", PSEL, 64'd0);
    check("t1_after_grant", grant, 64'd0);

    // Contention: requester 0 owned the last transfer, so requester 1 leads.
    rd_val = 32'hA5A5_0000;
    base = done_cnt;
    push(1, 32'h200, 1'b0, 32'hA5A5_0000, 1'b0);
    push(0, 32'h100, 1'b0, 32'hA5A5_0000, 1'b0);
    push(1, 32'h200, 1'b0, 32'hA5A5_0000, 1'b0);
    push(0, 32'h100, 1'b0, 32'hA5A5_0000, 1'b0);
    issue(0, 32'h100, 1'b0, 32'h0);
    issue(1, 32'h200, 1'b0, 32'h0);
    wait_done(base + 4);
    req_valid = '0;

    // Read with three wait states; PWDATA keeps the last write value.
    wait_states = 3;
    rd_val = 32'h1234_5678;
    base = done_cnt;
    push(1, 32'h20, 1'b0, 32'h1234_5678, 1'b0);
    issue(1, 32'h20, 1'b0, 32'h0);
    @(negedge HCLK); @(negedge HCLK);
    check("t3_setup_paddr", PADDR, 64'h20);
    check("t3_setup_pwrite", PWRITE, 64'd0);
    check("t3_pwdata_held", PWDATA, 64'hDEAD_BEEF);
    wait_done(base + 1);
    req_valid = '0;
    check("t3_penable_cycles", 64'(last_pen_run), 64'd4);
    wait_states = 0;

    // Slave error followed by a clean transfer.
    slverr = 1'b1;
    base = done_cnt;
    push(0, 32'h44, 1'b1, 32'h0, 1'b1);
    issue(0, 32'h44, 1'b1, 32'h55);
    wait_done(base + 1);
    req_valid = '0;
    slverr = 1'b0;
    push(1, 32'h48, 1'b1, 32'h0, 1'b0);
    issue(1, 32'h48, 1'b1, 32'h66);
    wait_done(base + 2);
    req_valid = '0;

`ifdef APB_TIMEOUT_EN
    // Stalled slave: timeout on the 16th ACCESS cycle, then the pending requester proceeds.
    wait_states = 100000;
    rd_val = 32'hCAFE_0001;
    base = done_cnt;
    push(0, 32'h80, 1'b0, 32'h0, 1'b1);
    push(1, 32'h84, 1'b0, 32'hCAFE_0001, 1'b0);
    issue(0, 32'h80, 1'b0, 32'h0);
    issue(1, 32'h84, 1'b0, 32'h0);
    wait_done(base + 1);
    check("t5_timeout_cycles", 64'(last_pen_run), 64'd16);
    req_valid[0] = 1'b0;
    wait_states = 0;
    @(negedge HCLK);
    check("t5_psel_low", PSEL, 64'd0);
    wait_done(base + 2);
    req_valid = '0;
`endif

    // Reset during a wait state aborts silently; arbitration restarts at requester 0.
    wait_states = 100000;
    issue(0, 32'h90, 1'b0, 32'h0);
    @(negedge HCLK); @(negedge HCLK); @(negedge HCLK);
    check("t6_in_access", PENABLE, 64'd1);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    req_valid = '0;
    @(negedge HCLK);
    @(negedge HCLK);
    check_idle_outputs("t6_reset");
    wait_states = 0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    base = done_cnt;
    push(0, 32'h300, 1'b1, 32'h0, 1'b0);
    push(1, 32'h304, 1'b1, 32'h0, 1'b0);
    issue(1, 32'h304, 1'b1, 32'h11);
    issue(0, 32'h300, 1'b1, 32'h22);
    wait_done(base + 2);
    req_valid = '0;

    repeat (3) @(posedge HCLK);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
